// File: rtl/acq_regs_pkg.sv
// ---------------------------------------------------------------------------
// acq_regs_pkg
// Shared register map for the acquisition path. The AXI-Lite register block,
// the run controller and the data generator import this package so that they
// all agree on word indices and bit positions.
//   - control/status word indices into the flattened 32-bit word buses
//   - bit positions inside the control and status flag words
//   - run sequencer state enum
//   - minimum frame period and the helper that applies it
// ---------------------------------------------------------------------------
package acq_regs_pkg;

  // Control word indices
  localparam int CTRL_RUN_IDX        = 0;
  localparam int CTRL_PERIOD_IDX     = 1;
  localparam int CTRL_MAX_FRAMES_IDX = 2;

  // Control word 0 bit positions
  localparam int CTRL_RUN_ENABLE_BIT  = 0;
  localparam int CTRL_CLEAR_STATS_BIT = 1;

  // Status word indices
  localparam int STATUS_FLAGS_IDX       = 0;
  localparam int STATUS_FRAMES_IDX      = 1;
  localparam int STATUS_TS_LO_IDX       = 2;
  localparam int STATUS_TS_HI_IDX       = 3;
  localparam int STATUS_OVERRUN_CNT_IDX = 4;

  // Status word 0 bit positions
  localparam int ST_RUNNING_BIT  = 0;
  localparam int ST_DRAINING_BIT = 1;
  localparam int ST_DONE_BIT     = 2;
  localparam int ST_OVERRUN_BIT  = 3;

  // Shortest legal frame period in clock cycles
  localparam logic [31:0] MIN_FRAME_PERIOD = 32'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } acq_state_e;

  // Periods below the minimum (0 and 1) behave as the minimum.
  function automatic logic [31:0] clamp_period(input logic [31:0] period);
    return (period < MIN_FRAME_PERIOD) ? MIN_FRAME_PERIOD : period;
  endfunction

endpackage

// File: rtl/acq_period_timer.sv
// ---------------------------------------------------------------------------
// acq_period_timer
// Frame slot timer. period_cnt counts 0..P-1 while advance is high and holds
// otherwise; a slot is due whenever period_cnt is 0.
//   pl_clk        in   clock
//   pl_rst        in   synchronous active-high reset
//   clear         in   restart the count at 0 (run entry)
//   advance       in   count this cycle (sequencer in RUN)
//   frame_period  in   requested period in cycles, clamped to the minimum
//   due           out  a frame slot falls on this cycle
// ---------------------------------------------------------------------------
module acq_period_timer
  import acq_regs_pkg::*;
(
  input  logic        pl_clk,
  input  logic        pl_rst,
  input  logic        clear,
  input  logic        advance,
  input  logic [31:0] frame_period,
  output logic        due
);

  logic [31:0] period_cnt;
  logic [31:0] period_eff;

  assign period_eff = clamp_period(frame_period);

  // The >= compare (not ==) makes a period shrunk below the current count
  // wrap on the very next cycle instead of running up to 2^32.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge pl_clk) begin
    if (pl_rst || clear) begin
      period_cnt <= '0;
    end else if (advance) begin
      period_cnt <= (period_cnt >= period_eff - 32'd1) ? '0 : period_cnt + 32'd1;
    end
  end

  assign due = (period_cnt == '0);

endmodule

// File: rtl/acq_run_controller.sv
// ---------------------------------------------------------------------------
// acq_run_controller
// Acquisition run sequencer. Decodes the control words, runs the
// IDLE/RUN/DRAIN state machine, issues one-cycle frame strobes to the
// downstream engine and packs the status words for the register block.
//   pl_clk           in   clock, all logic on its rising edge
//   pl_rst           in   synchronous active-high reset
//   ctrl_regs_pl     in   N_CTRL control words, word k at [32k+31:32k]
//   status_regs_pl   out  N_STATUS status words, same packing, unused = 0
//   frame_start      out  one-cycle frame strobe
//   frame_index      out  0-based frame number, valid with frame_start
//   frame_timestamp  out  run timestamp, valid with frame_start
//   frame_busy       in   downstream engine still processing a frame
// ---------------------------------------------------------------------------
module acq_run_controller
  import acq_regs_pkg::*;
#(
  parameter int N_CTRL   = 22,
  parameter int N_STATUS = 11
) (
  input  logic                  pl_clk,
  input  logic                  pl_rst,
  input  logic [32*N_CTRL-1:0]  ctrl_regs_pl,
  output logic [32*N_STATUS-1:0] status_regs_pl,
  output logic                  frame_start,
  output logic [31:0]           frame_index,
  output logic [63:0]           frame_timestamp,
  input  logic                  frame_busy
);

  acq_state_e state_q, state_d;

  logic        run_en, clr_stats, run_en_q, clr_q, run_rise, clr_rise;
  logic [31:0] frame_period, max_frames;
  logic        due, enter_run, issue, skip, finish;
  logic [31:0] frame_count, overrun_count;
  logic [63:0] timestamp;
  logic        overrun, done;
  logic [32*N_STATUS-1:0] status_d, status_q;
  logic        unused_ctrl;

  assign run_en       = ctrl_regs_pl[32*CTRL_RUN_IDX + CTRL_RUN_ENABLE_BIT];
  assign clr_stats    = ctrl_regs_pl[32*CTRL_RUN_IDX + CTRL_CLEAR_STATS_BIT];
  assign frame_period = ctrl_regs_pl[32*CTRL_PERIOD_IDX +: 32];
  assign max_frames   = ctrl_regs_pl[32*CTRL_MAX_FRAMES_IDX +: 32];
  assign unused_ctrl  = ^ctrl_regs_pl;

  assign run_rise = run_en & ~run_en_q;
  assign clr_rise = clr_stats & ~clr_q;

  acq_period_timer u_timer (
    .pl_clk       (pl_clk),
    .pl_rst       (pl_rst),
    .clear        (enter_run),
    .advance      (state_q == RUN),
    .frame_period (frame_period),
    .due          (due)
  );

  always_ff @(posedge pl_clk) begin
    if (pl_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    enter_run = 1'b0;
    issue     = 1'b0;
    skip      = 1'b0;
    finish    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run_rise) begin
          state_d   = RUN;
          enter_run = 1'b1;
        end
      end
      RUN: begin
        // Dropping run_enable wins over a due slot: no strobe, no overrun.
        if (!run_en) begin
          state_d = DRAIN;
        end else if (due) begin
          if (frame_busy) begin
            skip = 1'b1;
          end else begin
            issue = 1'b1;
            if (max_frames != '0 && frame_count + 32'd1 == max_frames) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!frame_busy) begin
          state_d = IDLE;
          finish  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pl_clk) begin
    if (pl_rst) begin
      // NOTE: edge-detect history resets high so a run_enable still asserted
      // through reset is not mistaken for a fresh rising edge.
      run_en_q        <= 1'b1;
      clr_q           <= 1'b1;
      frame_count     <= '0;
      timestamp       <= '0;
      overrun_count   <= '0;
      overrun         <= 1'b0;
      done            <= 1'b0;
      frame_start     <= 1'b0;
      frame_index     <= '0;
      frame_timestamp <= '0;
    end else begin
      run_en_q    <= run_en;
      clr_q       <= clr_stats;
      frame_start <= issue;

      if (enter_run)           timestamp <= '0;
      else if (state_q == RUN) timestamp <= timestamp + 64'd1;

      if (enter_run) begin
        frame_count <= '0;
      end else if (issue) begin
        frame_count     <= frame_count + 32'd1;
        frame_index     <= frame_count;
        frame_timestamp <= timestamp;
      end

      if (clr_rise || enter_run) done <= 1'b0;
      else if (finish)           done <= 1'b1;

      if (clr_rise) begin
        overrun_count <= '0;
        overrun       <= 1'b0;
      end else if (skip) begin
        overrun <= 1'b1;
        if (overrun_count != '1) overrun_count <= overrun_count + 32'd1;
      end
    end
  end

  // Status is packed from registered state and registered once more, so both
  // timestamp halves always come from the same latched frame.
  always_comb begin
    status_d = '0;
    status_d[32*STATUS_FLAGS_IDX + ST_RUNNING_BIT]  = (state_q == RUN);
    status_d[32*STATUS_FLAGS_IDX + ST_DRAINING_BIT] = (state_q == DRAIN);
    status_d[32*STATUS_FLAGS_IDX + ST_DONE_BIT]     = done;
    status_d[32*STATUS_FLAGS_IDX + ST_OVERRUN_BIT]  = overrun;
    status_d[32*STATUS_FRAMES_IDX      +: 32] = frame_count;
    status_d[32*STATUS_TS_LO_IDX       +: 32] = frame_timestamp[31:0];
    status_d[32*STATUS_TS_HI_IDX       +: 32] = frame_timestamp[63:32];
    status_d[32*STATUS_OVERRUN_CNT_IDX +: 32] = overrun_count;
  end

  always_ff @(posedge pl_clk) begin
    if (pl_rst) status_q <= '0;
    else        status_q <= status_d;
  end

  assign status_regs_pl = status_q;

endmodule
